// File: rtl/lu_serial_seq.sv
// Bit-serial sequencer for a 1-bit logic unit: feeds operand bit pairs
// LSB first and gathers the unit's replies into a WIDTH-bit result word.
module lu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             lu_a,
    output logic             lu_b,
    output logic [2:0]       lu_sel,
    input  logic             lu_y
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [2:0]       sel_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic             run;

    assign run = (state == S_RUN);

    // New bit enters at the MSB so bit 0 ends up at acc[0] after WIDTH shifts.
    assign acc_nx = (acc >> 1) | (WIDTH'(lu_y) << (WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            sel_r  <= 3'b000;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
        end else if (run) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            acc  <= acc_nx;
            if (cnt == LAST) begin
                result <= acc_nx;
                cnt    <= '0;
                state  <= S_DONE;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (start) begin
            // IDLE and DONE both accept a request
            sh_a  <= op_a;
            sh_b  <= op_b;
            sel_r <= op_sel;
            cnt   <= '0;
            acc   <= '0;
            state <= S_RUN;
        end else begin
            state <= S_IDLE;
        end
    end

    assign busy   = run;
    assign done   = (state == S_DONE);
    assign lu_a   = run & sh_a[0];
    assign lu_b   = run & sh_b[0];
    assign lu_sel = sel_r;

endmodule

// File: tb/tb_lu_serial_seq.sv
// Randomized self-checking bench for lu_serial_seq with a behavioural
// 1-bit logic unit attached and a word-level reference model.
module tb_lu_serial_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [2:0]   op_sel = 3'b000;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         lu_a;
    logic         lu_b;
    logic [2:0]   lu_sel;
    logic         lu_y;

    int n_chk = 0;
    int n_pass = 0;

    logic [W-1:0] exp_res = '0;
    logic [2:0]   exp_sel = 3'b000;

    lu_serial_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .op_sel (op_sel),
        .busy   (busy),
        .done   (done),
        .result (result),
        .lu_a   (lu_a),
        .lu_b   (lu_b),
        .lu_sel (lu_sel),
        .lu_y   (lu_y)
    );

    always #5 clk = ~clk;

    // The 1-bit logic unit the sequencer drives
    always_comb begin
        lu_y = 1'b0;
        case (lu_sel)
            3'b000: lu_y = ~lu_a;
            3'b001: lu_y = lu_a & lu_b;
            3'b010: lu_y = ~(lu_a & lu_b);
            3'b011: lu_y = lu_a | lu_b;
            3'b100: lu_y = ~(lu_a | lu_b);
            3'b101: lu_y = lu_a ^ lu_b;
            3'b110: lu_y = ~(lu_a ^ lu_b);
            default: lu_y = 1'b0;
        endcase
    end

    function automatic logic [W-1:0] ref_op(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [2:0]   s
    );
        case (s)
            3'd0: return ~a;
            3'd1: return a & b;
            3'd2: return ~(a & b);
            3'd3: return a | b;
            3'd4: return ~(a | b);
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Issue one op from IDLE or DONE; returns positioned in its DONE cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] s, input bit inject);
        logic [W-1:0] prev;
        prev = exp_res;
        op_a = a;
        op_b = b;
        op_sel = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            check($sformatf("busy_run%0d", i), 32'(busy), 32'd1);
            check($sformatf("done_run%0d", i), 32'(done), 32'd0);
            check($sformatf("lu_a_bit%0d", i), 32'(lu_a), 32'(a[i]));
            check($sformatf("lu_b_bit%0d", i), 32'(lu_b), 32'(b[i]));
            check($sformatf("lu_sel_run%0d", i), 32'(lu_sel), 32'(s));
            check($sformatf("res_hold%0d", i), 32'(result), 32'(prev));
            if (inject && i == 2) begin
                start = 1'b1;
                op_a = ~a;
                op_b = ~b;
                op_sel = s ^ 3'b101;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        exp_res = ref_op(a, b, s);
        exp_sel = s;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("result", 32'(result), 32'(exp_res));
        check("lu_a_done", 32'(lu_a), 32'd0);
        check("lu_sel_done", 32'(lu_sel), 32'(exp_sel));
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_result", 32'(result), 32'(exp_res));
        check("idle_lu_ab", 32'({lu_a, lu_b}), 32'd0);
        check("idle_lu_sel", 32'(lu_sel), 32'(exp_sel));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   rs;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_lu", 32'({lu_a, lu_b, lu_sel}), 32'd0);
        reset = 1'b0;
        idle_cycle();

        run_op(8'hC5, 8'h0F, 3'b001, 1'b0);
        check("and_c5_0f", 32'(result), 32'h05);
        run_op(8'hC5, 8'h0F, 3'b101, 1'b0);
        check("xor_c5_0f", 32'(result), 32'hCA);
        run_op(8'hC5, 8'h0F, 3'b100, 1'b0);
        check("nor_c5_0f", 32'(result), 32'h30);
        idle_cycle();

        run_op(8'hC5, 8'h5A, 3'b000, 1'b0);
        check("not_c5", 32'(result), 32'h3A);
        idle_cycle();
        run_op(8'hC5, 8'h0F, 3'b111, 1'b0);
        check("sel111", 32'(result), 32'h00);
        idle_cycle();

        run_op(8'hC5, 8'h0F, 3'b001, 1'b1);
        check("ign_start", 32'(result), 32'h05);
        idle_cycle();
        idle_cycle();

        // Asynchronous reset mid-cycle in RUN cycle 5
        op_a = 8'h5A;
        op_b = 8'hA7;
        op_sel = 3'b110;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        check("arst_lu", 32'({lu_a, lu_b, lu_sel}), 32'd0);
        exp_res = '0;
        exp_sel = 3'b000;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycle();
        idle_cycle();
        run_op(8'hFF, 8'h00, 3'b011, 1'b0);
        check("or_ff_00", 32'(result), 32'hFF);
        idle_cycle();

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 3'($urandom_range(0, 7));
            run_op(ra, rb, rs, ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lu_serial_seq.md
# lu_serial_seq

Bit-serial sequencer that sits directly upstream of the 1-bit logic unit (NOT/AND/NAND/OR/NOR/XOR/XNOR, 3-bit select) and also consumes its output. It accepts two WIDTH-bit operands and an operation code through a start/busy/done handshake. It then drives the logic unit one bit pair per clock, LSB first, and assembles the returned bits into a WIDTH-bit word result.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled on clk when the block is ready (IDLE or DONE).
- op_a  in  WIDTH  operand A; captured with start.
- op_b  in  WIDTH  operand B; captured with start.
- op_sel  in  3  operation code; captured with start. 000 NOT A, 001 AND, 010 NAND, 011 OR, 100 NOR, 101 XOR, 110 XNOR, 111 unused (unit returns 0).
- busy  out  1  high in every RUN cycle.
- done  out  1  one-cycle pulse; result valid from this cycle.
- result  out  WIDTH  last completed word; held until the next completion.
- lu_a  out  1  bit of A currently presented to the logic unit.
- lu_b  out  1  bit of B currently presented to the logic unit.
- lu_sel  out  3  select driven to the logic unit.
- lu_y  in  1  logic-unit output; combinational response to lu_a/lu_b/lu_sel in the same cycle.

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE, start=1: load op_a/op_b into shift registers sh_a/sh_b, op_sel into sel_r; clear bit counter cnt; go to RUN. If start=0, stay in IDLE.
- RUN:
  - lu_a=sh_a[0], lu_b=sh_b[0], lu_sel=sel_r.
  - Each edge: shift lu_y into the MSB of accumulator acc, shifting acc right; shift sh_a/sh_b right by 1; cnt+1.
  - When cnt = WIDTH-1 at an edge: copy the final acc value (including this cycle's lu_y) into result and go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1: behave as IDLE with start (back-to-back); go straight to RUN.
  - start=0: go to IDLE.
- After WIDTH bits, result[i] = op(op_a[i], op_b[i]) for every i; bit 0 is processed first.
- cnt width: clog2(WIDTH), minimum 1 bit.
- start while in RUN is ignored; operands and select are not re-sampled.
- In IDLE and DONE, lu_a=0, lu_b=0 and lu_sel=sel_r (last op). The logic unit output is don't-care there.
- op_sel=111 runs normally and yields result 0.
- WIDTH=1: a single RUN cycle.

## Timing
- Reset (async assert, any state):
  - state IDLE.
  - busy=0, done=0, result=0, lu_a=0, lu_b=0, lu_sel=000, cnt=0, acc=0.
  - Reset in RUN aborts the operation: no done pulse, and result is cleared to 0.
- start sampled at edge k (in IDLE):
  - RUN occupies cycles k+1 .. k+WIDTH; busy is high exactly WIDTH cycles.
  - done is high in cycle k+WIDTH+1; result updates at the same edge.
- Throughput: back-to-back starts give one operation per WIDTH+1 cycles.
- result changes only at the edge that enters DONE, or on reset.
- busy and done are never high together.
- lu_y must settle within the cycle, so the combinational path lu_a→lu_y→acc fits in one clock.

## Test plan
- WIDTH=8, A=0xC5, B=0x0F, sel=001, one start pulse → busy for 8 cycles, done pulse on cycle 9, result=0x05.
- Same operands, back-to-back starts asserted in the DONE cycle with sel=101 then sel=100 → results 0xCA then 0x30; each op takes 9 cycles, with no idle cycle between them.
- A=0xC5, sel=000 → result=0x3A (B ignored). A=0xC5, B=0x0F, sel=111 → result=0x00 with a normal done pulse.
- Pulse start again at RUN cycle 3 with different operands → ignored; result equals the first operation (0x05 for the AND case), one done pulse only.
- Assert reset asynchronously, mid-cycle, during RUN cycle 5 → busy, done and result drop to 0 immediately with no done pulse. Next start with A=0xFF, B=0x00, sel=011 → result=0xFF.
- Check the lu_a/lu_b sequence against op_a/op_b bit 0..7 on every RUN cycle. In IDLE after reset, check busy=0, done=0, result=0.
